// File: rtl/amba_axi4lite_write_arbiter.sv
// Shares one AXI4-Lite write path (AW/W/B) among NUM_REQ managers, one write outstanding at a time.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
//
// state | meaning
// IDLE  | no grant; arbitrate on S_AWVALID
// XFER  | lane g owns AW/W; wait until both have handshaken
// RESP  | forward B from the subordinate to lane g
module amba_axi4lite_write_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 28,
    parameter int DATA_WIDTH    = 32,
    localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,

    input  logic [NUM_REQ-1:0]               S_AWVALID,
    output logic [NUM_REQ-1:0]               S_AWREADY,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] S_AWADDR,
    input  logic [NUM_REQ*3-1:0]             S_AWPROT,
    input  logic [NUM_REQ-1:0]               S_WVALID,
    output logic [NUM_REQ-1:0]               S_WREADY,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    S_WDATA,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    S_WSTRB,
    output logic [NUM_REQ-1:0]               S_BVALID,
    input  logic [NUM_REQ-1:0]               S_BREADY,
    output logic [NUM_REQ*2-1:0]             S_BRESP,

    output logic                             M_AWVALID,
    input  logic                             M_AWREADY,
    output logic [ADDRESS_WIDTH-1:0]         M_AWADDR,
    output logic [2:0]                       M_AWPROT,
    output logic                             M_WVALID,
    input  logic                             M_WREADY,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [STRB_WIDTH-1:0]            M_WSTRB,
    input  logic                             M_BVALID,
    output logic                             M_BREADY,
    input  logic [1:0]                       M_BRESP
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] lp_q, lp_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic             in_xfer, in_resp;
    logic             aw_hs, w_hs, b_hs;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [NUM_REQ-1:0] grant_oh;

    logic [ADDRESS_WIDTH-1:0] awaddr_lane [NUM_REQ];
    logic [2:0]               awprot_lane [NUM_REQ];
    logic [DATA_WIDTH-1:0]    wdata_lane  [NUM_REQ];
    logic [STRB_WIDTH-1:0]    wstrb_lane  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign awaddr_lane[i] = S_AWADDR[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign awprot_lane[i] = S_AWPROT[i*3 +: 3];
        assign wdata_lane[i]  = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_lane[i]  = S_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
        assign grant_oh[i]    = (g_q == IDX_W'(i));
        assign S_BRESP[i*2 +: 2] = M_BRESP;
    end

    // Later loop iterations overwrite earlier ones, so iterate from the
    // lowest-priority candidate to the highest.
`ifdef AXIL_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (S_AWVALID[i]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_pos;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        rr_pos    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_pos = IDX_W'((int'(lp_q) + k) % NUM_REQ);
            if (S_AWVALID[rr_pos]) begin
                arb_found = 1'b1;
                arb_idx   = rr_pos;
            end
        end
    end
`endif

    assign in_xfer = (state_q == XFER);
    assign in_resp = (state_q == RESP);

    assign M_AWVALID = in_xfer & S_AWVALID[g_q] & ~aw_done_q;
    assign M_WVALID  = in_xfer & S_WVALID[g_q] & ~w_done_q;
    assign M_BREADY  = in_resp & S_BREADY[g_q];

    assign S_AWREADY = grant_oh & {NUM_REQ{in_xfer & M_AWREADY & ~aw_done_q}};
    assign S_WREADY  = grant_oh & {NUM_REQ{in_xfer & M_WREADY & ~w_done_q}};
    assign S_BVALID  = grant_oh & {NUM_REQ{in_resp & M_BVALID}};

    assign M_AWADDR = in_xfer ? awaddr_lane[g_q] : '0;
    assign M_AWPROT = in_xfer ? awprot_lane[g_q] : '0;
    assign M_WDATA  = in_xfer ? wdata_lane[g_q]  : '0;
    assign M_WSTRB  = in_xfer ? wstrb_lane[g_q]  : '0;

    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID & M_WREADY;
    assign b_hs  = M_BVALID & M_BREADY;

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        lp_d      = lp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    g_d     = arb_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                // AW and W may finish in either order or together.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            RESP: begin
                if (b_hs) begin
                    lp_d    = g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            g_q       <= '0;
            lp_q      <= IDX_W'(NUM_REQ - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            lp_q      <= lp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_amba_axi4lite_write_arbiter.sv
// Directed bench for amba_axi4lite_write_arbiter (NUM_REQ=2, 28-bit address, 32-bit data).
// Expected grant order follows AXIL_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_amba_axi4lite_write_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [NR-1:0]     S_AWVALID;
    logic [NR-1:0]     S_AWREADY;
    logic [NR*AW-1:0]  S_AWADDR;
    logic [NR*3-1:0]   S_AWPROT;
    logic [NR-1:0]     S_WVALID;
    logic [NR-1:0]     S_WREADY;
    logic [NR*DW-1:0]  S_WDATA;
    logic [NR*SW-1:0]  S_WSTRB;
    logic [NR-1:0]     S_BVALID;
    logic [NR-1:0]     S_BREADY;
    logic [NR*2-1:0]   S_BRESP;
    logic              M_AWVALID;
    logic              M_AWREADY;
    logic [AW-1:0]     M_AWADDR;
    logic [2:0]        M_AWPROT;
    logic              M_WVALID;
    logic              M_WREADY;
    logic [DW-1:0]     M_WDATA;
    logic [SW-1:0]     M_WSTRB;
    logic              M_BVALID;
    logic              M_BREADY;
    logic [1:0]        M_BRESP;

    int checks = 0;
    int failures = 0;

    amba_axi4lite_write_arbiter #(
        .NUM_REQ      (NR),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY),
        .S_AWADDR (S_AWADDR),
        .S_AWPROT (S_AWPROT),
        .S_WVALID (S_WVALID),
        .S_WREADY (S_WREADY),
        .S_WDATA  (S_WDATA),
        .S_WSTRB  (S_WSTRB),
        .S_BVALID (S_BVALID),
        .S_BREADY (S_BREADY),
        .S_BRESP  (S_BRESP),
        .M_AWVALID(M_AWVALID),
        .M_AWREADY(M_AWREADY),
        .M_AWADDR (M_AWADDR),
        .M_AWPROT (M_AWPROT),
        .M_WVALID (M_WVALID),
        .M_WREADY (M_WREADY),
        .M_WDATA  (M_WDATA),
        .M_WSTRB  (M_WSTRB),
        .M_BVALID (M_BVALID),
        .M_BREADY (M_BREADY),
        .M_BRESP  (M_BRESP)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        S_AWVALID = '0; S_AWADDR = '0; S_AWPROT = '0;
        S_WVALID  = '0; S_WDATA  = '0; S_WSTRB  = '0;
        S_BREADY  = '0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        clear_inputs();
        repeat (2) tick();
        ARESETn = 1'b1;
    endtask

    task automatic set_aw(input int lane, input logic [AW-1:0] addr, input logic [2:0] prot);
        S_AWADDR[lane*AW +: AW] = addr;
        S_AWPROT[lane*3 +: 3]   = prot;
    endtask

    task automatic set_w(input int lane, input logic [DW-1:0] data, input logic [SW-1:0] strb);
        S_WDATA[lane*DW +: DW] = data;
        S_WSTRB[lane*SW +: SW] = strb;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        clear_inputs();
        S_AWVALID = '1; S_WVALID = '1; S_BREADY = '1;
        M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b1;
        set_aw(0, 28'h0000ABC, 3'b111);
        repeat (2) tick();
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b0) begin failures++; $display("FAIL reset_m_awvalid got=%b exp=0", M_AWVALID); end
        checks++; if (M_WVALID !== 1'b0) begin failures++; $display("FAIL reset_m_wvalid got=%b exp=0", M_WVALID); end
        checks++; if (M_BREADY !== 1'b0) begin failures++; $display("FAIL reset_m_bready got=%b exp=0", M_BREADY); end
        checks++; if (S_AWREADY !== 2'b00) begin failures++; $display("FAIL reset_s_awready got=%b exp=00", S_AWREADY); end
        checks++; if (S_WREADY !== 2'b00) begin failures++; $display("FAIL reset_s_wready got=%b exp=00", S_WREADY); end
        checks++; if (S_BVALID !== 2'b00) begin failures++; $display("FAIL reset_s_bvalid got=%b exp=00", S_BVALID); end
        checks++; if (M_AWADDR !== 28'h0) begin failures++; $display("FAIL reset_m_awaddr got=%h exp=0", M_AWADDR); end
        checks++; if (dut.lp_q !== 1'b1) begin failures++; $display("FAIL reset_lp got=%0d exp=1", dut.lp_q); end
        tick();
        ARESETn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_write();
        apply_reset();
        S_AWVALID = 2'b01; S_WVALID = 2'b01;
        set_aw(0, 28'h0000010, 3'b000);
        set_w(0, 32'hDEADBEEF, 4'hF);
        M_AWREADY = 1'b1; M_WREADY = 1'b1;
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", M_AWVALID); end
        tick();
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b1) begin failures++; $display("FAIL single_awvalid got=%b exp=1", M_AWVALID); end
        checks++; if (M_AWADDR !== 28'h10) begin failures++; $display("FAIL single_awaddr got=%h exp=10", M_AWADDR); end
        checks++; if (M_WDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wdata got=%h exp=deadbeef", M_WDATA); end
        checks++; if (M_WSTRB !== 4'hF) begin failures++; $display("FAIL single_wstrb got=%h exp=f", M_WSTRB); end
        checks++; if (S_AWREADY !== 2'b01) begin failures++; $display("FAIL single_s_awready got=%b exp=01", S_AWREADY); end
        checks++; if (S_WREADY !== 2'b01) begin failures++; $display("FAIL single_s_wready got=%b exp=01", S_WREADY); end
        tick();
        S_AWVALID = 2'b00; S_WVALID = 2'b00;
        M_BVALID = 1'b1; M_BRESP = 2'b00; S_BREADY = 2'b01;
        @(negedge ACLK);
        checks++; if (S_BVALID !== 2'b01) begin failures++; $display("FAIL single_s_bvalid got=%b exp=01", S_BVALID); end
        checks++; if (S_BRESP[1:0] !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b exp=00", S_BRESP[1:0]); end
        checks++; if (M_BREADY !== 1'b1) begin failures++; $display("FAIL single_m_bready got=%b exp=1", M_BREADY); end
        tick();
        M_BVALID = 1'b0; S_BREADY = 2'b00;
        @(negedge ACLK);
        checks++; if (S_BVALID !== 2'b00) begin failures++; $display("FAIL single_bvalid_after got=%b exp=00", S_BVALID); end
        checks++; if (M_AWVALID !== 1'b0) begin failures++; $display("FAIL single_idle_awvalid got=%b exp=0", M_AWVALID); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int exp_order [4];
        int n;
        int last;
        int got;
        logic [DW-1:0] exp_data;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        apply_reset();
        S_AWVALID = 2'b11; S_WVALID = 2'b11; S_BREADY = 2'b11;
        set_aw(0, 28'h0000100, 3'b001);
        set_aw(1, 28'h0000200, 3'b010);
        set_w(0, 32'h11110000, 4'h1);
        set_w(1, 32'h22220000, 4'h2);
        M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b1; M_BRESP = 2'b00;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge ACLK);
            if (M_AWVALID === 1'b1) begin
                got = (M_AWADDR == 28'h200) ? 1 : 0;
                exp_data = (exp_order[n] == 1) ? 32'h22220000 : 32'h11110000;
                checks++; if (got != exp_order[n]) begin failures++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", n, got, exp_order[n]); end
                checks++; if (M_WDATA !== exp_data) begin failures++; $display("FAIL b2b_wdata%0d got=%h exp=%h", n, M_WDATA, exp_data); end
                if (n > 0) begin
                    checks++; if (cyc - last != 3) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=3", n, cyc - last); end
                end
                last = cyc;
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
        tick();
        clear_inputs();
    endtask

    task automatic test_w_before_aw();
        logic [1:0] st;
        apply_reset();
        M_AWREADY = 1'b1; M_WREADY = 1'b0;
        S_WVALID = 2'b10;
        set_w(1, 32'hCAFEF00D, 4'h3);
        set_aw(1, 28'h0000ABC, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++; if (S_WREADY !== 2'b00 || M_WVALID !== 1'b0) begin failures++; $display("FAIL early_w_stall%0d got=%b/%b exp=00/0", i, S_WREADY, M_WVALID); end
            tick();
        end
        S_AWVALID = 2'b10;
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b0) begin failures++; $display("FAIL early_w_latency got=%b exp=0", M_AWVALID); end
        tick();
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b1) begin failures++; $display("FAIL early_w_awvalid got=%b exp=1", M_AWVALID); end
        checks++; if (M_AWADDR !== 28'hABC) begin failures++; $display("FAIL early_w_awaddr got=%h exp=abc", M_AWADDR); end
        checks++; if (M_AWPROT !== 3'b010) begin failures++; $display("FAIL early_w_awprot got=%b exp=010", M_AWPROT); end
        checks++; if (S_AWREADY !== 2'b10) begin failures++; $display("FAIL early_w_s_awready got=%b exp=10", S_AWREADY); end
        checks++; if (S_WREADY !== 2'b00) begin failures++; $display("FAIL early_w_wready_low got=%b exp=00", S_WREADY); end
        tick();
        S_AWVALID = 2'b00;
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b0 || S_AWREADY !== 2'b00) begin failures++; $display("FAIL early_w_aw_done got=%b/%b exp=0/00", M_AWVALID, S_AWREADY); end
        checks++; if (M_WVALID !== 1'b1) begin failures++; $display("FAIL early_w_wvalid_hold got=%b exp=1", M_WVALID); end
        tick();
        M_WREADY = 1'b1;
        @(negedge ACLK);
        checks++; if (S_WREADY !== 2'b10) begin failures++; $display("FAIL early_w_s_wready got=%b exp=10", S_WREADY); end
        checks++; if (M_WDATA !== 32'hCAFEF00D || M_WSTRB !== 4'h3) begin failures++; $display("FAIL early_w_wdata got=%h/%h exp=cafef00d/3", M_WDATA, M_WSTRB); end
        tick();
        S_WVALID = 2'b00; M_WREADY = 1'b0;
        M_BVALID = 1'b1; M_BRESP = 2'b00; S_BREADY = 2'b10;
        @(negedge ACLK);
        checks++; if (S_BVALID !== 2'b10) begin failures++; $display("FAIL early_w_s_bvalid got=%b exp=10", S_BVALID); end
        tick();
        M_BVALID = 1'b0; S_BREADY = 2'b00;
        @(negedge ACLK);
        st = dut.state_q;
        checks++; if (S_BVALID !== 2'b00) begin failures++; $display("FAIL early_w_single_b got=%b exp=00", S_BVALID); end
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL early_w_state got=%0d exp=0", st); end
        checks++; if (dut.aw_done_q !== 1'b0 || dut.w_done_q !== 1'b0) begin failures++; $display("FAIL early_w_flags got=%b%b exp=00", dut.aw_done_q, dut.w_done_q); end
        checks++; if (dut.lp_q !== 1'b1) begin failures++; $display("FAIL early_w_lp got=%0d exp=1", dut.lp_q); end
        clear_inputs();
    endtask

    task automatic test_slverr_backpressure();
        int low_cnt;
        apply_reset();
        S_AWVALID = 2'b01; S_WVALID = 2'b01;
        set_aw(0, 28'h0000044, 3'b000);
        set_w(0, 32'h12345678, 4'hF);
        M_AWREADY = 1'b1; M_WREADY = 1'b1;
        tick();
        tick();
        S_AWVALID = 2'b00; S_WVALID = 2'b00;
        M_BVALID = 1'b1; M_BRESP = 2'b10; S_BREADY = 2'b10;
        low_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (M_BREADY === 1'b0) low_cnt++;
            checks++; if (S_BVALID !== 2'b01) begin failures++; $display("FAIL slverr_bvalid_wait%0d got=%b exp=01", i, S_BVALID); end
            tick();
        end
        checks++; if (low_cnt != 4) begin failures++; $display("FAIL slverr_bready_low got=%0d exp=4", low_cnt); end
        S_BREADY = 2'b11;
        @(negedge ACLK);
        checks++; if (M_BREADY !== 1'b1) begin failures++; $display("FAIL slverr_bready got=%b exp=1", M_BREADY); end
        checks++; if (S_BVALID !== 2'b01) begin failures++; $display("FAIL slverr_lane_only got=%b exp=01", S_BVALID); end
        checks++; if (S_BRESP !== 4'b1010) begin failures++; $display("FAIL slverr_bresp got=%b exp=1010", S_BRESP); end
        tick();
        M_BVALID = 1'b0; S_BREADY = 2'b00;
        @(negedge ACLK);
        checks++; if (S_BVALID !== 2'b00) begin failures++; $display("FAIL slverr_bvalid_after got=%b exp=00", S_BVALID); end
        clear_inputs();
    endtask

    task automatic test_reset_in_resp();
        apply_reset();
        S_AWVALID = 2'b10; S_WVALID = 2'b10;
        set_aw(1, 28'h0000300, 3'b000);
        set_w(1, 32'hA5A5A5A5, 4'hF);
        set_aw(0, 28'h0000500, 3'b000);
        M_AWREADY = 1'b1; M_WREADY = 1'b1;
        tick();
        tick();
        S_WVALID = 2'b00; S_AWVALID = 2'b11;
        M_BVALID = 1'b1; M_BRESP = 2'b00; S_BREADY = 2'b00;
        @(negedge ACLK);
        checks++; if (S_BVALID !== 2'b10) begin failures++; $display("FAIL rst_resp_pre_bvalid got=%b exp=10", S_BVALID); end
        #2;
        S_BREADY = 2'b10;
        ARESETn = 1'b0;
        #1;
        checks++; if (S_BVALID !== 2'b00) begin failures++; $display("FAIL rst_resp_bvalid got=%b exp=00", S_BVALID); end
        checks++; if (M_BREADY !== 1'b0) begin failures++; $display("FAIL rst_resp_bready got=%b exp=0", M_BREADY); end
        checks++; if (M_AWVALID !== 1'b0 || M_WVALID !== 1'b0) begin failures++; $display("FAIL rst_resp_mvalid got=%b/%b exp=0/0", M_AWVALID, M_WVALID); end
        checks++; if (S_AWREADY !== 2'b00 || S_WREADY !== 2'b00) begin failures++; $display("FAIL rst_resp_sready got=%b/%b exp=00/00", S_AWREADY, S_WREADY); end
        tick();
        ARESETn = 1'b1;
        @(negedge ACLK);
        checks++; if (dut.lp_q !== 1'b1) begin failures++; $display("FAIL rst_resp_lp got=%0d exp=1", dut.lp_q); end
        checks++; if (M_AWVALID !== 1'b0) begin failures++; $display("FAIL rst_resp_no_replay got=%b exp=0", M_AWVALID); end
        tick();
        @(negedge ACLK);
        checks++; if (M_AWVALID !== 1'b1 || M_AWADDR !== 28'h500) begin failures++; $display("FAIL rst_resp_req0_wins got=%b/%h exp=1/500", M_AWVALID, M_AWADDR); end
        tick();
        clear_inputs();
    endtask

    initial begin
        ARESETn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_w_before_aw();
        test_slverr_backpressure();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
